// File: rtl/softmax_max_stage_if.sv
// Handshake bundle for the softmax max stage: score input and replay output.
// Both sides use valid/ready: a word moves on the rising clock edge where
// valid and ready are both high; the sender holds its data stable while
// valid is high and ready is low.
interface softmax_max_stage_if #(
    parameter int DATALENGTH = 32
) ();
    logic [DATALENGTH-1:0] Datain;
    logic                  InValid;
    logic                  InReady;
    logic [DATALENGTH-1:0] DataOut;
    logic [DATALENGTH-1:0] NegMax;
    logic                  OutValid;
    logic                  OutReady;
    logic                  OutLast;

    // Upstream/downstream environment side
    modport master (
        output Datain, InValid, OutReady,
        input  InReady, DataOut, NegMax, OutValid, OutLast
    );

    // Block side
    modport slave (
        input  Datain, InValid, OutReady,
        output InReady, DataOut, NegMax, OutValid, OutLast
    );
endinterface

// File: rtl/softmax_max_stage.sv
// Softmax input stage: buffers one vector of single-precision scores, finds
// the maximum with compare-only logic, then replays every score together with
// the negated maximum so the downstream adder can form x - max.
module softmax_max_stage #(
    parameter int DATALENGTH = 32,
    parameter int VECLEN     = 5
) (
    input  logic                  Clock,
    input  logic                  Reset,
    softmax_max_stage_if.slave    bus,
    output logic [0:0]            StateDbg
);
    localparam int IDXW = (VECLEN > 1) ? $clog2(VECLEN) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(VECLEN - 1);
    localparam int MSB = DATALENGTH - 1;

    localparam logic [0:0] LOAD = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;

    logic [0:0]            state;
    logic [IDXW-1:0]       count;
    logic [DATALENGTH-1:0] max_q;
    logic [DATALENGTH-1:0] max_nxt;
    logic [DATALENGTH-1:0] neg_max_q;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic                  in_xfer;
    logic                  out_xfer;
    logic [DATALENGTH-1:0] mem [VECLEN];

    // a > b on IEEE-754 bit patterns; +0 and -0 compare equal, NaN undefined
    function automatic logic fp_gt(input logic [DATALENGTH-1:0] a,
                                   input logic [DATALENGTH-1:0] b);
        logic sa;
        logic sb;
        logic [MSB-1:0] ma;
        logic [MSB-1:0] mb;
        sa = a[MSB];
        sb = b[MSB];
        ma = a[MSB-1:0];
        mb = b[MSB-1:0];
        if (sa != sb) begin
            if ((ma == '0) && (mb == '0)) fp_gt = 1'b0;
            else                          fp_gt = ~sa;
        end else if (!sa) begin
            fp_gt = (ma > mb);
        end else begin
            fp_gt = (ma < mb);
        end
    endfunction

    assign in_xfer  = bus.InValid && in_ready_q;
    assign out_xfer = out_valid_q && bus.OutReady;

    // Running maximum including the word being accepted; element 0 always loads
    always_comb begin
        max_nxt = max_q;
        if ((count == '0) || fp_gt(bus.Datain, max_q)) max_nxt = bus.Datain;
    end

    // Control FSM: LOAD collects VECLEN words, EMIT replays them
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state       <= LOAD;
            count       <= '0;
            max_q       <= '0;
            neg_max_q   <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    if (in_xfer) begin
                        max_q <= max_nxt;
                        if (count == LAST_IDX) begin
                            state       <= EMIT;
                            count       <= '0;
                            neg_max_q   <= {~max_nxt[MSB], max_nxt[MSB-1:0]};
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            count <= count + IDXW'(1);
                        end
                    end
                end
                default: begin
                    if (out_xfer) begin
                        if (count == LAST_IDX) begin
                            state       <= LOAD;
                            count       <= '0;
                            out_valid_q <= 1'b0;
                            in_ready_q  <= 1'b1;
                        end else begin
                            count <= count + IDXW'(1);
                        end
                    end
                end
            endcase
        end
    end

    // Score buffer; contents are don't-care after reset so it has none
    always_ff @(posedge Clock) begin
        if (in_xfer) mem[count] <= bus.Datain;
    end

    assign bus.InReady  = in_ready_q;
    assign bus.OutValid = out_valid_q;
    assign bus.DataOut  = out_valid_q ? mem[count] : '0;
    assign bus.NegMax   = neg_max_q;
    assign bus.OutLast  = out_valid_q && (count == LAST_IDX);
    assign StateDbg     = state;
endmodule
